// File: rtl/apb_multi_slave_wrapper.sv
// APB subsystem: command-driven master FSM, address decoder, NUM_SLAVES register-file slaves
// with programmable wait states, and an erroring default slave for unmapped addresses.
module apb_multi_slave_wrapper #(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned SLV_ADDR_WIDTH = 3,
  parameter int unsigned NUM_SLAVES     = 3,
  parameter int unsigned WAIT_STATES    = 1
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  transfer,
  input  logic [ADDR_WIDTH-1:0] apb_paddr,
  input  logic [DATA_WIDTH-1:0] apb_pwdata,
  input  logic                  apb_control,
  output logic [DATA_WIDTH-1:0] apb_spwdata,
  output logic [DATA_WIDTH-1:0] apb_prdata,
  output logic                  apb_done,
  output logic                  apb_error
);

  localparam int unsigned SelWidth = ADDR_WIDTH - SLV_ADDR_WIDTH;
  localparam int unsigned Depth    = 2 ** SLV_ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   mem_q [NUM_SLAVES][Depth];
  logic [3:0]              wait_cnt_q [NUM_SLAVES];

  logic [SelWidth-1:0]       sel;
  logic [SLV_ADDR_WIDTH-1:0] word;
  logic [NUM_SLAVES-1:0]     psel;
  logic                      psel_any;
  logic                      penable;
  logic                      pready;
  logic                      pslverr;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      capture;
  logic                      complete;

  assign sel      = addr_q[ADDR_WIDTH-1:SLV_ADDR_WIDTH];
  assign word     = addr_q[SLV_ADDR_WIDTH-1:0];
  assign psel_any = (state_q != StIdle);
  assign penable  = (state_q == StAccess);
  assign complete = penable & pready;
  assign capture  = transfer & ((state_q == StIdle) | complete);

  // Defaults describe the default slave: immediate ready, error, zero data.
  always_comb begin
    psel    = '0;
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (sel == SelWidth'(i)) begin
        psel[i] = psel_any;
        pready  = (wait_cnt_q[i] == 4'(WAIT_STATES));
        pslverr = 1'b0;
        prdata  = mem_q[i][word];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (transfer) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (pready) state_d = transfer ? StSetup : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      apb_spwdata <= '0;
      apb_prdata  <= '0;
      apb_done    <= 1'b0;
      apb_error   <= 1'b0;
    end else begin
      state_q  <= state_d;
      apb_done <= complete;
      if (capture) begin
        addr_q  <= apb_paddr;
        wdata_q <= apb_pwdata;
        write_q <= apb_control;
      end
      if (complete) begin
        apb_error <= pslverr;
        if (write_q && !pslverr) apb_spwdata <= wdata_q;
        if (!write_q)            apb_prdata  <= prdata;
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
        wait_cnt_q[i] <= '0;
        for (int j = 0; j < int'(Depth); j++) mem_q[i][j] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
        if (state_q == StSetup) begin
          wait_cnt_q[i] <= '0;
        end else if (psel[i] && penable && !pready) begin
          wait_cnt_q[i] <= wait_cnt_q[i] + 4'd1;
        end
        if (psel[i] && penable && pready && write_q) mem_q[i][word] <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_apb_multi_slave_wrapper.sv
// Randomized bench for apb_multi_slave_wrapper against a flat address-indexed reference model.
module tb_apb_multi_slave_wrapper;

  localparam int AW  = 5;
  localparam int DW  = 16;
  localparam int SAW = 3;
  localparam int NS  = 3;
  localparam int WS  = 1;

  logic          pclk = 1'b0;
  logic          preset_n = 1'b0;
  logic          transfer = 1'b0;
  logic [AW-1:0] apb_paddr = '0;
  logic [DW-1:0] apb_pwdata = '0;
  logic          apb_control = 1'b0;
  logic [DW-1:0] apb_spwdata;
  logic [DW-1:0] apb_prdata;
  logic          apb_done;
  logic          apb_error;

  apb_multi_slave_wrapper #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .SLV_ADDR_WIDTH(SAW),
    .NUM_SLAVES    (NS),
    .WAIT_STATES   (WS)
  ) dut (
    .pclk       (pclk),
    .preset_n   (preset_n),
    .transfer   (transfer),
    .apb_paddr  (apb_paddr),
    .apb_pwdata (apb_pwdata),
    .apb_control(apb_control),
    .apb_spwdata(apb_spwdata),
    .apb_prdata (apb_prdata),
    .apb_done   (apb_done),
    .apb_error  (apb_error)
  );

  always #5 pclk = ~pclk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one word per command address; unmapped addresses never hold data.
  logic [DW-1:0] m_mem [2**AW];
  logic [DW-1:0] m_spw;
  logic [DW-1:0] m_prd;
  logic          m_err;

  logic [AW-1:0] c_addr [8];
  logic [DW-1:0] c_data [8];
  logic          c_wr   [8];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit is_mapped(input logic [AW-1:0] a);
    return (int'(a) / (2 ** SAW)) < NS;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 2 ** AW; a++) m_mem[a] = '0;
    m_spw = '0;
    m_prd = '0;
    m_err = 1'b0;
  endtask

  task automatic model_apply(input int idx);
    bit ok;
    ok    = is_mapped(c_addr[idx]);
    m_err = !ok;
    if (c_wr[idx]) begin
      if (ok) begin
        m_mem[c_addr[idx]] = c_data[idx];
        m_spw = c_data[idx];
      end
    end else begin
      m_prd = ok ? m_mem[c_addr[idx]] : '0;
    end
  endtask

  task automatic set_cmd(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic wr);
    c_addr[idx] = a;
    c_data[idx] = d;
    c_wr[idx]   = wr;
  endtask

  task automatic drive_cmd(input int idx);
    apb_paddr   = c_addr[idx];
    apb_pwdata  = c_data[idx];
    apb_control = c_wr[idx];
  endtask

  task automatic drive_junk();
    apb_paddr   = AW'($urandom);
    apb_pwdata  = DW'($urandom);
    apb_control = 1'($urandom);
  endtask

  // Issues n commands with transfer held high; each next command is presented right after
  // the edge that captured the previous one.
  task automatic run_burst(input int n);
    int  c;
    bit  seen;
    drive_cmd(0);
    transfer = 1'b1;
    @(posedge pclk); #1;
    if (n > 1) drive_cmd(1);
    else transfer = 1'b0;
    for (int i = 0; i < n; i++) begin
      c = 0;
      seen = 1'b0;
      while (!seen && c < 20) begin
        if (!transfer) drive_junk();
        @(posedge pclk); #1;
        c++;
        if (apb_done) seen = 1'b1;
      end
      check_eq("done_timeout", 32'(seen), 32'd1);
      if (!seen) begin
        transfer = 1'b0;
        return;
      end
      check_eq("latency", 32'(c), is_mapped(c_addr[i]) ? 32'(2 + WS) : 32'd2);
      model_apply(i);
      check_eq("error", 32'(apb_error), 32'(m_err));
      check_eq("spwdata", 32'(apb_spwdata), 32'(m_spw));
      check_eq("prdata", 32'(apb_prdata), 32'(m_prd));
      if (i + 2 < n) drive_cmd(i + 2);
      else transfer = 1'b0;
    end
    @(posedge pclk); #1;
    check_eq("done_pulse_end", 32'(apb_done), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    check_eq("rst_done", 32'(apb_done), 32'd0);
    check_eq("rst_error", 32'(apb_error), 32'd0);
    check_eq("rst_spwdata", 32'(apb_spwdata), 32'd0);
    check_eq("rst_prdata", 32'(apb_prdata), 32'd0);
    preset_n = 1'b1;
    @(posedge pclk); #1;

    set_cmd(0, 5'h03, 16'hA5A5, 1'b1);
    run_burst(1);
    check_eq("spw_a5a5", 32'(apb_spwdata), 32'h0000_A5A5);

    set_cmd(0, 5'h0B, 16'h1234, 1'b1);
    run_burst(1);
    set_cmd(0, 5'h03, 16'h0000, 1'b0);
    run_burst(1);
    check_eq("rd_slv0", 32'(apb_prdata), 32'h0000_A5A5);
    set_cmd(0, 5'h0B, 16'h0000, 1'b0);
    run_burst(1);
    check_eq("rd_slv1", 32'(apb_prdata), 32'h0000_1234);

    set_cmd(0, 5'h1A, 16'hFFFF, 1'b1);
    run_burst(1);
    check_eq("unmapped_wr_spw", 32'(apb_spwdata), 32'h0000_1234);
    set_cmd(0, 5'h1A, 16'h0000, 1'b0);
    run_burst(1);
    check_eq("unmapped_rd_err", 32'(apb_error), 32'd1);

    for (int i = 0; i < 8; i++) set_cmd(i, AW'(5'h10 + i), DW'($urandom), 1'b1);
    run_burst(8);
    for (int i = 0; i < 8; i++) set_cmd(i, AW'(5'h10 + i), 16'h0000, 1'b0);
    run_burst(8);

    // Reset in the middle of ACCESS must abort the write and clear everything.
    set_cmd(0, 5'h04, 16'h5555, 1'b1);
    drive_cmd(0);
    transfer = 1'b1;
    @(posedge pclk); #1;
    transfer = 1'b0;
    @(posedge pclk); #1;
    preset_n = 1'b0;
    #1;
    check_eq("abort_done", 32'(apb_done), 32'd0);
    check_eq("abort_spwdata", 32'(apb_spwdata), 32'd0);
    check_eq("abort_prdata", 32'(apb_prdata), 32'd0);
    check_eq("abort_error", 32'(apb_error), 32'd0);
    @(posedge pclk); #1;
    preset_n = 1'b1;
    model_reset();
    repeat (3) begin
      @(posedge pclk); #1;
      check_eq("abort_no_done", 32'(apb_done), 32'd0);
    end
    set_cmd(0, 5'h04, 16'h0000, 1'b0);
    set_cmd(1, 5'h03, 16'h0000, 1'b0);
    run_burst(2);

    for (int k = 0; k < 40; k++) begin
      int n;
      n = int'($urandom_range(1, 5));
      for (int i = 0; i < n; i++) begin
        logic [AW-1:0] a;
        a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, NS * 8 - 1));
        set_cmd(i, a, DW'($urandom), 1'($urandom));
      end
      run_burst(n);
    end

    for (int b = 0; b < NS; b++) begin
      for (int i = 0; i < 8; i++) set_cmd(i, AW'(b * 8 + i), 16'h0000, 1'b0);
      run_burst(8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb_multi_slave_wrapper.md
# apb_multi_slave_wrapper

Parametrised successor to the single-slave APB wrapper. Contains an APB master FSM, an address decoder and `NUM_SLAVES` register-file slaves with programmable wait states. Unmapped addresses get a `PSLVERR` error response. Sits between a simple command interface (`transfer`/address/data/control) and on-chip register storage. It is the self-contained APB subsystem used by block-level benches and small SoC shells.

## Interface
Parameters:
- `ADDR_WIDTH`, 5: total command address width.
- `DATA_WIDTH`, 16: data width of every slave word.
- `SLV_ADDR_WIDTH`, 3: in-slave word address width; each slave holds 2**`SLV_ADDR_WIDTH` words. Legal range is 1 to `ADDR_WIDTH`-1.
- `NUM_SLAVES`, 3: populated slaves. Legal range is 1 to 2**(`ADDR_WIDTH`-`SLV_ADDR_WIDTH`).
- `WAIT_STATES`, 1: extra ACCESS cycles each mapped slave inserts before `PREADY` (0–15).

Ports:
- `pclk` in 1: clock. Everything is rising-edge.
- `preset_n` in 1: asynchronous, active-low reset.
- `transfer` in 1: request. While high, commands are issued back-to-back.
- `apb_paddr` in `ADDR_WIDTH`: command address. Upper bits select the slave; low `SLV_ADDR_WIDTH` bits select the word.
- `apb_pwdata` in `DATA_WIDTH`: write data.
- `apb_control` in 1: 1 = write, 0 = read.
- `apb_spwdata` out `DATA_WIDTH`: data most recently written into any slave.
- `apb_prdata` out `DATA_WIDTH`: data from the most recent completed read.
- `apb_done` out 1: one-cycle pulse per completed transfer.
- `apb_error` out 1: `PSLVERR` of the last completed transfer. Held until the next completion.

## Operation
- Master FSM states:
  - IDLE: PSEL=0, PENABLE=0.
  - SETUP: PSEL=1, PENABLE=0, exactly one cycle.
  - ACCESS: PSEL=1, PENABLE=1, held until PREADY.
- IDLE→SETUP on an edge where `transfer`=1. On that edge `apb_paddr`/`apb_pwdata`/`apb_control` are captured into command registers.
- SETUP→ACCESS unconditionally.
- ACCESS with PREADY=1:
  - to SETUP if `transfer`=1 (new command captured on that edge);
  - otherwise to IDLE.
- Inputs are sampled only at capture edges. Changes between captures have no effect.
- Decode: sel = `paddr[ADDR_WIDTH-1:SLV_ADDR_WIDTH]`.
  - sel < `NUM_SLAVES`: PSEL of that slave only.
  - Otherwise the internal default slave responds: PREADY=1 in the first ACCESS cycle, PSLVERR=1, no storage written, read data 0.
- Mapped slave:
  - A per-slave wait counter clears on SETUP and increments during ACCESS.
  - PREADY=1 when the counter equals `WAIT_STATES`. PSLVERR=0.
  - Write commits to word `paddr[SLV_ADDR_WIDTH-1:0]` on the PREADY edge.
  - Read data is valid combinationally during the PREADY cycle.
- Completion edge (ACCESS and PREADY):
  - `apb_done` goes to 1 for one cycle.
  - `apb_error` is loaded with PSLVERR.
  - Successful write: `apb_spwdata` is loaded with the write data.
  - Read: `apb_prdata` is loaded with PRDATA (0 on error).
- An error write leaves `apb_spwdata` unchanged.

## Timing
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - All slave words, `apb_spwdata`, `apb_prdata`, `apb_done` and `apb_error` are 0.
  - Wait counters are 0.
- Reset during SETUP/ACCESS aborts the transfer: no write commits and no done pulse.
- Latency, where cycle 0 is the capture edge:
  - SETUP is cycle 1.
  - ACCESS occupies cycles 2 to 2+`WAIT_STATES`.
  - `apb_done` is visible in cycle 3+`WAIT_STATES`.
  - Unmapped addresses always take 3 cycles.
- Back-to-back throughput: one transfer per 2+`WAIT_STATES` cycles. There is no IDLE gap while `transfer` stays high.
- Address wrap: only the low `SLV_ADDR_WIDTH` bits index storage. No aliasing across slaves.
- Data width: stored and returned at exactly `DATA_WIDTH`. No truncation or extension.

## Test plan
All scenarios use the default parameters.
- Write 16'hA5A5 to 5'h03 (`transfer` pulsed on one capture edge, `apb_control`=1) -> `apb_done` pulse 4 cycles after capture, `apb_spwdata`=16'hA5A5, `apb_error`=0.
- Write 16'h1234 to 5'h0B (slave 1, word 3), then read 5'h03 and 5'h0B -> `apb_prdata`=16'hA5A5, then 16'h1234 (slave isolation).
- Write 16'hFFFF to 5'h1A (sel=3, unmapped) -> done in 3 cycles, `apb_error`=1, `apb_spwdata` unchanged. A subsequent read of 5'h1A -> `apb_prdata`=0, `apb_error`=1.
- Hold `transfer`=1 for 8 writes to 5'h10..5'h17 (slave 2) -> one `apb_done` every 3 cycles, PSEL continuously high. Readback returns each written value.
- Assert `preset_n`=0 during the ACCESS of a write of 16'h5555 to 5'h04 -> no done pulse, all outputs 0, readback of 5'h04 after release = 0.
- Toggle `apb_paddr`/`apb_pwdata` every cycle during one transfer -> only the values present on the capture edge take effect.
